// File: rtl/convert_bornes_bcd_seq_pkg.sv
// Shared types and constants for the bounds-to-BCD converter and display blocks.
package convert_bornes_bcd_seq_pkg;

  // Converter sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Double-dabble nibble correction: add BCD_ADJ_INC when nibble >= BCD_ADJ_THRESH
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_INC    = 4'd3;

  // Range width: one extra bit so that the full span 2^WIDTH_IN is representable
  function automatic int unsigned calc_rw(input int unsigned width_in);
    return width_in + 1;
  endfunction

  // 10^n, used to check that NB_DIGITS can hold the largest range
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

endpackage

// File: rtl/convert_bornes_bcd_seq_if.sv
// Request/result bus of the bounds-to-BCD converter.
// Optional CONV_BORNES_OFFSET_EN adds the 'mode' request signal.
interface convert_bornes_bcd_seq_if #(
  parameter int unsigned WIDTH_IN  = 7,
  parameter int unsigned NB_DIGITS = 3
);

  logic                     start;
  logic [WIDTH_IN-1:0]      d_min;
  logic [WIDTH_IN-1:0]      d_max;
`ifdef CONV_BORNES_OFFSET_EN
  logic                     mode;
`endif
  logic                     busy;
  logic                     done;
  logic [4*NB_DIGITS-1:0]   bcd;
  logic [NB_DIGITS-1:0]     en;
  logic                     err;

  // Requester side (bound selection logic)
  modport master (
    output start, d_min, d_max,
`ifdef CONV_BORNES_OFFSET_EN
    output mode,
`endif
    input  busy, done, bcd, en, err
  );

  // Converter side
  modport slave (
    input  start, d_min, d_max,
`ifdef CONV_BORNES_OFFSET_EN
    input  mode,
`endif
    output busy, done, bcd, en, err
  );

endinterface

// File: rtl/convert_bornes_bcd_seq_bcd_digit_adj.sv
// Combinational double-dabble correction of one BCD nibble.
module bcd_digit_adj (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_c_o
);

  import convert_bornes_bcd_seq_pkg::*;

  // Add 3 when the nibble would overflow past 9 after the next shift
  always_comb begin
    nib_c_o = nib_i;
    if (nib_i >= BCD_ADJ_THRESH) begin
      nib_c_o = nib_i + BCD_ADJ_INC;
    end
  end

endmodule

// File: rtl/convert_bornes_bcd_seq.sv
// Sequential bounds-to-BCD converter: range = d_max - d_min + 1 converted to
// NB_DIGITS BCD digits, one bit per clock, with leading-zero blanking.
// Optional CONV_BORNES_OFFSET_EN: mode=1 converts d_max - d_min instead.
module convert_bornes_bcd_seq #(
  parameter int unsigned WIDTH_IN  = 7,
  parameter int unsigned NB_DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  convert_bornes_bcd_seq_if.slave       bus
);

  import convert_bornes_bcd_seq_pkg::*;

  localparam int unsigned RW = calc_rw(WIDTH_IN);
  localparam int unsigned SW = RW + 1;
  localparam int unsigned BW = 4 * NB_DIGITS;
  localparam int unsigned CW = $clog2(RW + 1);

  // Largest range (2^WIDTH_IN) must fit in the digits
  if (pow10(NB_DIGITS) <= (64'd1 << WIDTH_IN)) begin : g_param_check
    $error("NB_DIGITS too small for WIDTH_IN");
  end

  state_e              state_q, state_d;
  logic [WIDTH_IN-1:0] dmin_q, dmin_d;
  logic [WIDTH_IN-1:0] dmax_q, dmax_d;
`ifdef CONV_BORNES_OFFSET_EN
  logic                mode_q, mode_d;
`endif
  logic [RW-1:0]       bin_q, bin_d;
  logic [BW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_int_q, err_int_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [NB_DIGITS-1:0] en_q, en_d;
  logic                err_q, err_d;

  logic [SW-1:0]       sub_c;
  logic [RW-1:0]       range_c;
  logic [BW-1:0]       acc_adj_c;
  logic [NB_DIGITS-1:0] en_calc_c;

  // Difference with one borrow bit; MSB set means d_min > d_max
  assign sub_c = SW'(dmax_q) - SW'(dmin_q);

`ifdef CONV_BORNES_OFFSET_EN
  assign range_c = mode_q ? sub_c[RW-1:0] : sub_c[RW-1:0] + RW'(1);
`else
  assign range_c = sub_c[RW-1:0] + RW'(1);
`endif

  // Per-nibble add-3 correction ahead of each shift
  for (genvar g = 0; g < NB_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_i   (acc_q[4*g +: 4]),
      .nib_c_o (acc_adj_c[4*g +: 4])
    );
  end

  // Digit enables: units always lit, higher digits lit if any digit at or above is non-zero
  always_comb begin
    en_calc_c = '0;
    en_calc_c[0] = 1'b1;
    for (int unsigned i = 1; i < NB_DIGITS; i++) begin
      en_calc_c[i] = |(acc_q >> (4 * i));
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    dmin_d    = dmin_q;
    dmax_d    = dmax_q;
`ifdef CONV_BORNES_OFFSET_EN
    mode_d    = mode_q;
`endif
    bin_d     = bin_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_int_d = err_int_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    en_d      = en_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dmin_d  = bus.d_min;
          dmax_d  = bus.d_max;
`ifdef CONV_BORNES_OFFSET_EN
          mode_d  = bus.mode;
`endif
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        bin_d     = range_c;
        acc_d     = '0;
        cnt_d     = CW'(RW);
        err_int_d = sub_c[RW];
        state_d   = SHIFT;
      end
      SHIFT: begin
        acc_d = {acc_adj_c[BW-2:0], bin_q[RW-1]};
        bin_d = {bin_q[RW-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (err_int_q) begin
          bcd_d = '0;
          en_d  = '0;
          err_d = 1'b1;
        end else begin
          bcd_d = acc_q;
          en_d  = en_calc_c;
          err_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dmin_q    <= '0;
      dmax_q    <= '0;
`ifdef CONV_BORNES_OFFSET_EN
      mode_q    <= 1'b0;
`endif
      bin_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_int_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      en_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dmin_q    <= dmin_d;
      dmax_q    <= dmax_d;
`ifdef CONV_BORNES_OFFSET_EN
      mode_q    <= mode_d;
`endif
      bin_q     <= bin_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_int_q <= err_int_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      en_q      <= en_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.en   = en_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_convert_bornes_bcd_seq.sv
// Randomized self-checking bench for convert_bornes_bcd_seq (7-bit bounds, 3 digits).
module tb_convert_bornes_bcd_seq;

  localparam int unsigned WIDTH_IN  = 7;
  localparam int unsigned NB_DIGITS = 3;
  localparam int          LAT       = WIDTH_IN + 3;
`ifdef CONV_BORNES_OFFSET_EN
  localparam bit OFFS_EN = 1'b1;
`else
  localparam bit OFFS_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  convert_bornes_bcd_seq_if #(.WIDTH_IN(WIDTH_IN), .NB_DIGITS(NB_DIGITS)) bus ();

  convert_bornes_bcd_seq #(.WIDTH_IN(WIDTH_IN), .NB_DIGITS(NB_DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  logic [11:0] prev_bcd;
  logic [2:0]  prev_en;
  logic        prev_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the range, decimal digit extraction
  task automatic model(input int dmin, input int dmax, input bit offs,
                       output logic [11:0] eb, output logic [2:0] ee, output bit e);
    int r;
    int p;
    e  = (dmin > dmax);
    r  = offs ? (dmax - dmin) : (dmax - dmin + 1);
    eb = '0;
    ee = '0;
    if (!e) begin
      ee[0] = 1'b1;
      p = 1;
      for (int i = 0; i < 3; i++) begin
        eb[4*i +: 4] = 4'((r / p) % 10);
        if (i > 0 && r >= p) ee[i] = 1'b1;
        p = p * 10;
      end
    end
  endtask

  // One full conversion with latency, pulse and hold checks
  task automatic run_conv(input int dmin, input int dmax, input bit md);
    logic [11:0] eb;
    logic [2:0]  ee;
    bit          e;
    bit          offs;
    int          cyc;
    offs = md && OFFS_EN;
    model(dmin, dmax, offs, eb, ee, e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.d_min = 7'(dmin);
    bus.d_max = 7'(dmax);
`ifdef CONV_BORNES_OFFSET_EN
    bus.mode  = md;
`endif
    @(posedge clk); #1;
    check_val("busy_after_start", 32'(bus.busy), 32'd1);
    check_val("done_cleared", 32'(bus.done), 32'd0);
    check_val("bcd_hold", 32'(bus.bcd), 32'(prev_bcd));
    @(negedge clk);
    bus.start = 1'b0;
    bus.d_min = 7'($urandom);
    bus.d_max = 7'($urandom);
`ifdef CONV_BORNES_OFFSET_EN
    bus.mode  = 1'($urandom);
`endif
    cyc = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) break;
      if (cyc > 40) break;
    end
    check_val("latency", 32'(cyc), 32'(LAT));
    check_val("busy_at_done", 32'(bus.busy), 32'd0);
    check_val("bcd", 32'(bus.bcd), 32'(eb));
    check_val("en", 32'(bus.en), 32'(ee));
    check_val("err", 32'(bus.err), 32'(e));
    prev_bcd = eb;
    prev_en  = ee;
    prev_err = e;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ndone;
    int a;
    int b;
    n_checks  = 0;
    n_errors  = 0;
    prev_bcd  = '0;
    prev_en   = '0;
    prev_err  = 1'b0;
    bus.start = 1'b0;
    bus.d_min = '0;
    bus.d_max = '0;
`ifdef CONV_BORNES_OFFSET_EN
    bus.mode  = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_bcd", 32'(bus.bcd), 32'd0);
    check_val("rst_en", 32'(bus.en), 32'd0);
    check_val("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_conv(1, 6, 1'b0);
    run_conv(1, 100, 1'b0);
    run_conv(0, 19, 1'b0);
    run_conv(0, 127, 1'b0);
    run_conv(42, 42, 1'b0);
    run_conv(5, 4, 1'b0);
    run_conv(3, 9, 1'b0);
    run_conv(127, 0, 1'b0);
    run_conv(0, 0, 1'b0);
`ifdef CONV_BORNES_OFFSET_EN
    run_conv(1, 20, 1'b1);
    check_val("offset_1_20", 32'(bus.bcd), 32'h019);
    run_conv(42, 42, 1'b1);
    run_conv(9, 8, 1'b1);
`endif

    // Randomized conversions, back-to-back
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, 127));
      b = int'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) b = a;
      run_conv(a, b, 1'($urandom));
    end

    // start while busy is ignored, single done pulse
    @(negedge clk);
    bus.start = 1'b1;
    bus.d_min = 7'd1;
    bus.d_max = 7'd20;
`ifdef CONV_BORNES_OFFSET_EN
    bus.mode  = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
      @(negedge clk);
      bus.start = (c == 3);
      if (c == 3) begin
        bus.d_min = 7'd1;
        bus.d_max = 7'd6;
      end
    end
    check_val("busy_start_ignored_pulses", 32'(ndone), 32'd1);
    check_val("busy_start_bcd", 32'(bus.bcd), 32'h020);
    check_val("busy_start_en", 32'(bus.en), 32'b011);
    check_val("busy_start_err", 32'(bus.err), 32'd0);

    // Reset mid-conversion aborts it
    @(negedge clk);
    bus.start = 1'b1;
    bus.d_min = 7'd0;
    bus.d_max = 7'd127;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", 32'(bus.busy), 32'd0);
    check_val("abort_bcd", 32'(bus.bcd), 32'd0);
    check_val("abort_en", 32'(bus.en), 32'd0);
    check_val("abort_err", 32'(bus.err), 32'd0);
    ndone = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check_val("abort_no_done", 32'(ndone), 32'd0);
    prev_bcd = '0;
    prev_en  = '0;
    prev_err = 1'b0;

    // Recovery after abort, error then clearing valid conversion
    run_conv(5, 4, 1'b0);
    run_conv(1, 6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/convert_bornes_bcd_seq.md
Name: convert_bornes_bcd_seq

Overview:
Sequential, parametrised successor to the combinational bounds-to-display converter used by the dice block.
- Takes a die's lower and upper bounds and computes the face count, range = d_max - d_min + 1.
- Converts the range to NB_DIGITS BCD digits with a shift-add-3 (double-dabble) engine, one bit per clock.
- Drives per-digit display enables with leading-zero blanking and a start/done handshake.
- Sits between the bound-selection logic and the 7-segment decoders.

Parameters:
WIDTH_IN, 7, width of d_min and d_max (unsigned).
NB_DIGITS, 3, number of BCD digits produced. Must satisfy 10^NB_DIGITS > 2^WIDTH_IN; elaboration error otherwise.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request a conversion; sampled only in IDLE.
d_min  in  WIDTH_IN  lower bound, unsigned.
d_max  in  WIDTH_IN  upper bound, unsigned.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse when outputs update.
bcd  out  4*NB_DIGITS  digits; nibble i = 10^i (nibble 0 = units, LSBs).
en  out  NB_DIGITS  digit enables; bit i drives digit i.
err  out  1  high when the last conversion had d_min > d_max.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, bcd=0, en=0, err=0, internal registers cleared. Reset mid-conversion aborts it; outputs return to reset values.
- Derived width: RW = WIDTH_IN+1.
  - Range is computed in RW bits: zero-extend both bounds, range = d_max + 1 - d_min.
  - Error condition: d_min > d_max is detected by the RW+1-bit borrow.
- FSM states:
  - IDLE: start=1 captures d_min/d_max at that edge (edge k); go to CALC; busy=1.
  - CALC (1 cycle): load range into the binary shift register; clear the BCD accumulator; bit counter = RW; latch err_int.
  - SHIFT (RW cycles): each cycle, every BCD nibble ≥5 gets +3, then shift {bcd_acc, bin} left by 1; decrement counter. Leave after the counter reaches 0.
  - DONE (1 cycle): register outputs, done=1, busy=0 on the next edge; go to IDLE.
- Latency:
  - done is high in the cycle following edge k+RW+2; default 10 cycles after start is sampled.
  - Latency is constant, including the error case.
  - Back-to-back: start may be asserted in the cycle done is high. It is sampled on the following IDLE edge, so 1 idle cycle minimum between conversions.
- start while busy: ignored, not queued.
- Inputs are sampled only at the start edge; later changes have no effect on the conversion in flight.
- Error (d_min > d_max): err=1, bcd=0, en=0 at done. Otherwise err=0.
- Enables: en[0]=1 always on a valid conversion. en[i] (i>0) = 1 if any nibble j≥i is non-zero, so leading zeros are blanked.
- Outputs hold their values between done pulses.
- Equal bounds (d_min = d_max) give range 1.
- Maximum range 2^WIDTH_IN (0..127 gives 128) is converted exactly.

Optional Feature:
- Macro: CONV_BORNES_OFFSET_EN.
- When defined:
  - Extra input mode (1 bit), captured at start.
  - mode=1 converts d_max - d_min (span without +1); mode=0 converts the normal range.
  - Error rule is unchanged.
- When undefined: port absent; always range = d_max - d_min + 1.

Decomposition:
- Shared package (shared by the dice and display blocks):
  - FSM state typedef {IDLE, CALC, SHIFT, DONE}.
  - Function computing RW from WIDTH_IN.
  - Constant for the BCD adjust threshold (5) and increment (3).
- One sub-module: bcd_digit_adj, combinational per-nibble add-3-if-≥5, instantiated NB_DIGITS times by generate.

Test Plan:
1. d_min=1, d_max=6, start pulse → done 10 cycles later: bcd=12'h006, en=3'b001, err=0.
2. d_min=1, d_max=100 → bcd=12'h100, en=3'b111; d_min=0, d_max=19 → bcd=12'h020, en=3'b011.
3. d_min=0, d_max=127 → bcd=12'h128, en=3'b111. d_min=d_max=42 → bcd=12'h001, en=3'b001.
4. d_min=5, d_max=4 → err=1, bcd=0, en=0, done still at 10 cycles. A following valid conversion clears err.
5. Handshake and reset:
   - Start on the first conversion (d_min=1, d_max=20, result 20).
   - Pulse start with d_min=1, d_max=6 at cycle 4 of that conversion → ignored; result stays 20; only one done pulse.
   - Start a new conversion and deassert rst_n at cycle 5 → all outputs 0 immediately, no done pulse.
6. CONV_BORNES_OFFSET_EN defined, mode=1, d_min=1, d_max=20 → bcd=12'h019, en=3'b011.
